instr_issue_seq: RTL
====================

// Module: instr_issue_seq
// PURPOSE
//   Upstream stage of the 4-bit ALU datapath. Holds a small program of 12-bit instruction
//   words {opcode[3:0], operandA[3:0], operandB[3:0]}, sequences it from address 0 on start,
//   decodes each word and issues opcode/operandA/operandB to the ALU with a valid/ready handshake.
//   Handles HALT and illegal opcodes locally, so only ADD/SUB/AND/OR (0000-0011) reach the ALU.
// PARAMETERS
//   OP_W    4   opcode width
//   DATA_W  4   operand width
//   DEPTH   16  instruction-buffer entries
//   ADDR_W  4   log2(DEPTH)
// PORTS
//   clk          in   1               clock, all state on rising edge
//   rst_n        in   1               asynchronous, active-low reset
//   load_en      in   1               write load_data into buffer at load_addr (IDLE only)
//   load_addr    in   ADDR_W          buffer write address
//   load_data    in   OP_W+2*DATA_W   instruction word {opcode, operandA, operandB}
//   start        in   1               begin execution at address 0 (IDLE only)
//   prog_len     in   ADDR_W+1        words to execute, 0..DEPTH, sampled on accepted start
//   abort        in   1               synchronous abort, return to IDLE
//   issue_valid  out  1               opcode/operandA/operandB hold a legal ALU instruction
//   issue_ready  in   1               ALU stage accepts this cycle
//   opcode       out  OP_W            issued opcode
//   operandA     out  DATA_W          issued operand A
//   operandB     out  DATA_W          issued operand B
//   busy         out  1               high in FETCH/DECODE/ISSUE
//   done         out  1               one-cycle pulse at program end
//   illegal_cnt  out  8               skipped illegal opcodes, saturates at 255, cleared on start
// BEHAVIOUR
//   Reset: state=IDLE, pc=0, every output 0. Buffer contents are not cleared.
//   FSM states: IDLE, FETCH, DECODE, ISSUE, DONE.
//   IDLE:
//     - load_en writes the buffer; load_en in any other state is ignored.
//     - start latches prog_len, clears pc and illegal_cnt.
//     - If prog_len=0, go to DONE; otherwise go to FETCH.
//     - If start and load_en arrive together, the load is performed and start is accepted.
//   FETCH: synchronous read of mem[pc], word registered; next state DECODE.
//   DECODE:
//     - Opcode 0000-0011: drive outputs, assert issue_valid, go to ISSUE.
//     - Opcode 1111 (HALT): go to DONE and stop at once, even if words remain.
//     - Other opcodes: illegal_cnt+1 (saturating), pc+1, then DONE if pc+1==len, else FETCH.
//   ISSUE:
//     - opcode/operandA/operandB stay stable while issue_valid && !issue_ready.
//     - On a handshake, drop issue_valid next cycle, pc+1, then DONE if pc+1==len, else FETCH.
//   Latency: accepted start -> issue_valid high 3 cycles later (FETCH, DECODE, ISSUE).
//   Throughput: at most 1 instruction per 3 cycles with issue_ready tied high.
//   DONE: done=1 for exactly one cycle, then IDLE; busy=0 in DONE.
//   start while not IDLE is ignored.
//   abort (any non-IDLE state): IDLE next cycle, issue_valid drops even if not accepted,
//   no done pulse; abort takes priority over a same-cycle handshake.
//   pc is ADDR_W+1 bits: len=DEPTH ends at pc==DEPTH with no address wrap.
//   rst_n low mid-program: all state clears immediately; outputs are 0 while rst_n is low.
// STRUCTURE
//   Shared package proc_pkg:
//     - OP_ADD=0000, OP_SUB=0001, OP_AND=0010, OP_OR=0011, OP_HALT=1111
//     - state encodings, instruction-word field slice constants
//   Sub-module instr_buf: DEPTH x (OP_W+2*DATA_W) RAM, one write port, registered read port.
// TESTING
//   T1 load {0000,3,4},{0001,9,2}, len=2, ready=1:
//      issues (0000,3,4) then (0001,9,2), each 3 cycles apart; done pulses once; illegal_cnt=0.
//   T2 backpressure, issue_ready=0 for 5 cycles on word 0:
//      issue_valid and fields held stable 5 cycles; issue advances only after ready=1.
//   T3 program {0010,F,5},{1111,0,0},{0011,1,1}, len=3:
//      only (0010,F,5) issued; HALT gives done; third word never issued.
//   T4 program {0111,1,1},{0011,6,9}, len=2:
//      illegal_cnt=1; only (0011,6,9) issued; len=0 start -> done 1 cycle later, no issue.
//   T5 abort while in ISSUE with ready=0: issue_valid=0 next cycle, IDLE, no done pulse;
//      restart runs cleanly from address 0.
//   T6 rst_n low in DECODE, and load_en/start while busy:
//      outputs 0 immediately; pc/state reset; buffer retains data; ignored writes leave buffer unchanged.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the ALU-datapath front end: opcodes, FSM states and
// the 12-bit instruction word layout {opcode, operandA, operandB}.
package proc_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned PC_W   = ADDR_W + 1;
    localparam int unsigned WORD_W = OP_W + 2 * DATA_W;
    localparam int unsigned CNT_W  = 8;

    localparam int unsigned OPC_LSB = 2 * DATA_W;
    localparam int unsigned OPA_LSB = DATA_W;
    localparam int unsigned OPB_LSB = 0;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
    localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] opa;
        logic [DATA_W-1:0] opb;
    } instr_t;

    function automatic instr_t unpack_word(input logic [WORD_W-1:0] w);
        instr_t u;
        u.opcode = w[OPC_LSB +: OP_W];
        u.opa    = w[OPA_LSB +: DATA_W];
        u.opb    = w[OPB_LSB +: DATA_W];
        return u;
    endfunction

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    endfunction

endpackage

// File: rtl/instr_buf.sv
// Instruction buffer: DEPTH x WORD_W RAM, one write port, registered read port.
// Contents are deliberately not reset so a program survives rst_n.
module instr_buf
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_issue_seq.sv
// Sequences a buffered program from address 0, skips illegal opcodes, stops on
// HALT, and issues ADD/SUB/AND/OR to the ALU over a valid/ready handshake.
module instr_issue_seq
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [WORD_W-1:0] load_data,
    input  logic              start,
    input  logic [PC_W-1:0]   prog_len,
    input  logic              abort,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [OP_W-1:0]   opcode,
    output logic [DATA_W-1:0] operandA,
    output logic [DATA_W-1:0] operandB,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  illegal_cnt
);

    state_t            state, state_d;
    logic [PC_W-1:0]   pc, pc_d, pc_inc, len, len_d;
    logic              issue_valid_d, busy_d, done_d;
    logic [OP_W-1:0]   opcode_d;
    logic [DATA_W-1:0] operand_a_d, operand_b_d;
    logic [CNT_W-1:0]  illegal_cnt_d;
    logic [WORD_W-1:0] rd_word;
    logic              buf_we, buf_re;
    instr_t            cur;

    assign buf_we = load_en && (state == ST_IDLE);
    assign buf_re = (state == ST_FETCH);
    assign cur    = unpack_word(rd_word);
    assign pc_inc = PC_W'(pc + 1'b1);

    instr_buf u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (buf_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (buf_re),
        .raddr (pc[ADDR_W-1:0]),
        .rdata (rd_word)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d       = state;
        pc_d          = pc;
        len_d         = len;
        issue_valid_d = issue_valid;
        opcode_d      = opcode;
        operand_a_d   = operandA;
        operand_b_d   = operandB;
        illegal_cnt_d = illegal_cnt;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    len_d         = prog_len;
                    pc_d          = '0;
                    illegal_cnt_d = '0;
                    state_d       = (prog_len == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_alu_op(cur.opcode)) begin
                    opcode_d      = cur.opcode;
                    operand_a_d   = cur.opa;
                    operand_b_d   = cur.opb;
                    issue_valid_d = 1'b1;
                    state_d       = ST_ISSUE;
                end else if (cur.opcode == OP_HALT) begin
                    state_d = ST_DONE;
                end else begin
                    if (illegal_cnt != '1) begin
                        illegal_cnt_d = CNT_W'(illegal_cnt + 1'b1);
                    end
                    pc_d    = pc_inc;
                    state_d = (pc_inc == len) ? ST_DONE : ST_FETCH;
                end
            end
            ST_ISSUE: begin
                if (issue_ready) begin
                    issue_valid_d = 1'b0;
                    pc_d          = pc_inc;
                    state_d       = (pc_inc == len) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over any same-cycle handshake or decode side effect.
        if (abort && (state != ST_IDLE)) begin
            state_d       = ST_IDLE;
            issue_valid_d = 1'b0;
            pc_d          = pc;
            illegal_cnt_d = illegal_cnt;
        end

        done_d = (state_d == ST_DONE);
        busy_d = state_d inside {ST_FETCH, ST_DECODE, ST_ISSUE};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= '0;
            len         <= '0;
            issue_valid <= 1'b0;
            opcode      <= '0;
            operandA    <= '0;
            operandB    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            len         <= len_d;
            issue_valid <= issue_valid_d;
            opcode      <= opcode_d;
            operandA    <= operand_a_d;
            operandB    <= operand_b_d;
            busy        <= busy_d;
            done        <= done_d;
            illegal_cnt <= illegal_cnt_d;
        end
    end

endmodule
